// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    typedef enum logic {OP_RD, OP_WR} dmem_op_t;

    localparam logic [31:0] DMEM_BAD_DATA = 32'hDEADBEEF;

    localparam int DMEM_LAT_MIN = 1;
    localparam int DMEM_LAT_MAX = 15;

    function automatic bit dmem_lat_ok(input int lat);
        return (lat >= DMEM_LAT_MIN) && (lat <= DMEM_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM: clocked write, combinational read of the addressed word.
module dmem_ram #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY cycles per access.
// Optional alignment checking is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic        CLOCK,
    input  logic        RESET_N,
    input  logic        MemRENABLE,
    input  logic        MemWENABLE,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] Read_Data,
    output logic        Stall,
    output logic        ReqConflict,
    output logic        AlignErr
);

    if (!dmem_lat_ok(LATENCY)) begin : g_bad_latency
        $error("dmem_responder: LATENCY must lie in 1..15");
    end

    localparam logic [3:0] CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_t        state, state_next;
    logic [3:0]         cnt, cnt_next;
    dmem_op_t           op_q;
    logic [ADDR_W-1:0]  idx_q;
    logic [31:0]        wdata_q;
    logic               conf_q, mis_q;

    logic               req, accept, complete;
    logic               mis_live;
    logic               cur_wr, cur_mis;
    logic [ADDR_W-1:0]  ram_idx;
    logic [31:0]        ram_wdata, ram_rdata;
    logic               ram_we;
    logic               unused_addr;

    assign req         = MemRENABLE | MemWENABLE;
    assign unused_addr = ^{Address[31:ADDR_W+2], Address[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_live = |Address[1:0];
    assign AlignErr = (state == RESP) && mis_q;
`else
    assign mis_live = 1'b0;
    assign AlignErr = 1'b0;
`endif

    assign ReqConflict = (state == RESP) && conf_q;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            cnt    <= 4'd0;
            op_q   <= OP_RD;
            conf_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (accept) begin
                op_q   <= MemWENABLE ? OP_WR : OP_RD;
                conf_q <= MemRENABLE & MemWENABLE;
                mis_q  <= mis_live;
            end
        end
    end

    // Address and store data need no reset: only consumed after an accept.
    always_ff @(posedge CLOCK) begin
        if (accept) begin
            idx_q   <= Address[ADDR_W+1:2];
            wdata_q <= WriteData;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        Stall      = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                Stall = req & RESET_N;
                if (req) begin
                    accept = 1'b1;
                    if (LATENCY == 1) begin
                        complete   = 1'b1;
                        state_next = RESP;
                    end else begin
                        cnt_next   = CNT_LOAD;
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                Stall = 1'b1;
                if (cnt == 4'd0) begin
                    complete   = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // With LATENCY==1 the access completes on the accept edge, so use live inputs in IDLE.
    always_comb begin
        if (state == IDLE) begin
            cur_wr    = MemWENABLE;
            cur_mis   = mis_live;
            ram_idx   = Address[ADDR_W+1:2];
            ram_wdata = WriteData;
        end else begin
            cur_wr    = (op_q == OP_WR);
            cur_mis   = mis_q;
            ram_idx   = idx_q;
            ram_wdata = wdata_q;
        end
    end

    assign ram_we = complete & cur_wr & ~cur_mis;

    dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (CLOCK),
        .we    (ram_we),
        .idx   (ram_idx),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            Read_Data <= 32'd0;
        end else if (complete && !cur_wr) begin
            Read_Data <= cur_mis ? DMEM_BAD_DATA : ram_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with LATENCY 2, 1 and 4.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_n;
    logic [2:0]  ren, wen;
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [31:0] rdata [3];
    logic [2:0]  stall, conf, aerr;

    logic [31:0] mem_m [3][256];
    logic [31:0] rd_m  [3];
    logic [31:0] exp_q [$];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(8), .LATENCY(2)) u_lat2 (
        .CLOCK(clk), .RESET_N(rst_n[0]), .MemRENABLE(ren[0]), .MemWENABLE(wen[0]),
        .Address(addr[0]), .WriteData(wdata[0]), .Read_Data(rdata[0]),
        .Stall(stall[0]), .ReqConflict(conf[0]), .AlignErr(aerr[0]));

    dmem_responder #(.ADDR_W(8), .LATENCY(1)) u_lat1 (
        .CLOCK(clk), .RESET_N(rst_n[1]), .MemRENABLE(ren[1]), .MemWENABLE(wen[1]),
        .Address(addr[1]), .WriteData(wdata[1]), .Read_Data(rdata[1]),
        .Stall(stall[1]), .ReqConflict(conf[1]), .AlignErr(aerr[1]));

    dmem_responder #(.ADDR_W(8), .LATENCY(4)) u_lat4 (
        .CLOCK(clk), .RESET_N(rst_n[2]), .MemRENABLE(ren[2]), .MemWENABLE(wen[2]),
        .Address(addr[2]), .WriteData(wdata[2]), .Read_Data(rdata[2]),
        .Stall(stall[2]), .ReqConflict(conf[2]), .AlignErr(aerr[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 1 : 4;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one request at a negedge and follow it through to the cycle after RESP.
    task automatic access(input int d, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] wd);
        int          n;
        int          idx;
        logic        ea;
        logic [31:0] e;
        idx = int'(a[9:2]);
        ea  = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        ea = (a[1:0] != 2'b00);
`endif
        if (w) begin
            if (!ea) mem_m[d][idx] = wd;
        end else begin
            rd_m[d] = ea ? 32'hDEADBEEF : mem_m[d][idx];
        end
        exp_q.push_back(rd_m[d]);

        ren[d] = r; wen[d] = w; addr[d] = a; wdata[d] = wd;
        #1;
        n = 0;
        while (stall[d] && n < 40) begin
            n++;
            @(posedge clk);
            @(negedge clk);
        end
        if (n >= 40) chk("stall_timeout", 32'(n), 32'd0);
        chk("stall_cycles", 32'(n), 32'(lat_of(d)));
        e = exp_q.pop_front();
        chk("read_data", rdata[d], e);
        chk("req_conflict", 32'(conf[d]), 32'(r && w));
        chk("align_err", 32'(aerr[d]), 32'(ea));
        ren[d] = 1'b0; wen[d] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_stall", 32'(stall[d]), 32'd0);
        chk("conflict_one_cycle", 32'(conf[d]), 32'd0);
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 256; i++) mem_m[d][i] = 32'd0;
            rd_m[d] = 32'd0;
            addr[d] = 32'd0; wdata[d] = 32'd0;
        end
        ren = '0; wen = '0; rst_n = '0;

        // Reset state and idle behaviour after release
        #3;
        for (int d = 0; d < 3; d++) begin
            chk("reset_read_data", rdata[d], 32'd0);
            chk("reset_stall", 32'(stall[d]), 32'd0);
        end
        @(negedge clk);
        rst_n = 3'b111;
        repeat (3) begin
            @(negedge clk);
            chk("idle_no_req_stall", 32'(stall), 32'd0);
        end

        // LATENCY=2 write then read, plus a read-data hold check across a write
        access(0, 1'b0, 1'b1, 32'h40, 32'h12345678);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
        access(0, 1'b0, 1'b1, 32'h44, 32'h0BADF00D);
        access(0, 1'b1, 1'b0, 32'h44, 32'h0);

        // Asynchronous reset mid-cycle clears Read_Data at once
        #3;
        rst_n[0] = 1'b0;
        #1;
        chk("async_reset_read_data", rdata[0], 32'd0);
        chk("async_reset_stall", 32'(stall[0]), 32'd0);
        rd_m[0] = 32'd0;
        @(negedge clk);
        rst_n[0] = 1'b1;

        // LATENCY=1 conflict: write wins, Read_Data untouched
        access(1, 1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
        access(1, 1'b1, 1'b0, 32'h10, 32'h0);
        access(1, 1'b0, 1'b1, 32'h14, 32'h13579BDF);
        access(1, 1'b1, 1'b0, 32'h14, 32'h0);

        // Address wrap modulo depth
        access(0, 1'b0, 1'b1, 32'h400, 32'hCAFEF00D);
        access(0, 1'b1, 1'b0, 32'h000, 32'h0);

        // LATENCY=4 write aborted by reset in the second WAIT cycle
        @(negedge clk);
        wen[2] = 1'b1; addr[2] = 32'h8; wdata[2] = 32'h1;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n[2] = 1'b0;
        #1;
        chk("abort_stall_drop", 32'(stall[2]), 32'd0);
        chk("abort_read_data", rdata[2], 32'd0);
        wen[2] = 1'b0;
        @(negedge clk);
        rst_n[2] = 1'b1;
        access(2, 1'b1, 1'b0, 32'h8, 32'h0);
        access(2, 1'b0, 1'b1, 32'hC, 32'h76543210);
        access(2, 1'b1, 1'b0, 32'hC, 32'h0);

`ifdef DMEM_ALIGN_CHECK_EN
        // Misaligned accesses: no commit, poison read data, AlignErr pulse
        access(0, 1'b0, 1'b1, 32'h42, 32'hFFFFFFFF);
        access(0, 1'b1, 1'b0, 32'h42, 32'h0);
        access(0, 1'b1, 1'b0, 32'h40, 32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
